// File: rtl/cc_game_sequencer.sv
// cc_game_sequencer: accepts one CC game record, streams it into the CC core
// (in_valid_1 cells/stripes, idle gap, in_valid_2 actions), waits for the
// score, returns it (or a timeout) on a response handshake, and flags CC
// output-protocol violations.
module cc_game_sequencer #(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 500
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [107:0] req_color,
    input  logic [23:0]  req_stripe_pos,
    input  logic [3:0]   req_stripe_type,
    input  logic [59:0]  req_act_pos,
    input  logic [19:0]  req_act_dir,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [6:0]   rsp_score,
    output logic         rsp_timeout,
    output logic         cc_in_valid_1,
    output logic         cc_in_valid_2,
    output logic [2:0]   cc_in_color,
    output logic [5:0]   cc_in_starting_pos,
    output logic         cc_in_stripe,
    output logic [1:0]   cc_in_action,
    input  logic         cc_out_valid,
    input  logic [6:0]   cc_out_score,
    output logic         proto_err
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] C_LOAD_LAST = CNT_W'(35);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] C_ACT_LAST  = CNT_W'(9);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_ACT,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_wait_inc;

    // Record storage, loaded once per accepted request.
    logic [107:0] r_color;
    logic [23:0]  r_stripe_pos;
    logic [3:0]   r_stripe_type;
    logic [59:0]  r_act_pos;
    logic [19:0]  r_act_dir;

    logic         w_accept;
    logic [107:0] w_color_src;
    logic [23:0]  w_stripe_pos_src;
    logic [3:0]   w_stripe_type_src;

    logic [2:0] w_cell    [36];
    logic [5:0] w_spos    [4];
    logic [5:0] w_apos    [10];
    logic [1:0] w_adir    [10];

    logic       w_req_ready_nxt;
    logic       w_rsp_valid_nxt;
    logic [6:0] w_score_nxt;
    logic       w_timeout_nxt;
    logic       w_v1_nxt;
    logic       w_v2_nxt;
    logic [2:0] w_color_nxt;
    logic [5:0] w_pos_nxt;
    logic       w_stripe_nxt;
    logic [1:0] w_action_nxt;

    logic       r_prev_out_valid;
    logic       w_proto_viol;

    assign w_accept   = (r_state == ST_IDLE) && req_valid && req_ready;
    assign w_wait_inc = r_cnt + CNT_W'(1);

    // Cell 0 and stripe 0 go out on the acceptance edge itself, before the
    // storage holds them, so in IDLE the stream reads straight from the ports.
    assign w_color_src       = (r_state == ST_IDLE) ? req_color       : r_color;
    assign w_stripe_pos_src  = (r_state == ST_IDLE) ? req_stripe_pos  : r_stripe_pos;
    assign w_stripe_type_src = (r_state == ST_IDLE) ? req_stripe_type : r_stripe_type;

    assign w_proto_viol = (cc_out_valid && (r_state != ST_WAIT))
                        || (cc_out_valid && r_prev_out_valid)
                        || (!cc_out_valid && (cc_out_score != 7'd0));

    // Unpack the flat record buses into indexable per-item views.
    always_comb begin
        for (int k = 0; k < 36; k++) w_cell[k] = w_color_src[3*k +: 3];
        for (int j = 0; j < 4; j++)  w_spos[j] = w_stripe_pos_src[6*j +: 6];
        for (int m = 0; m < 10; m++) begin
            w_apos[m] = r_act_pos[6*m +: 6];
            w_adir[m] = r_act_dir[2*m +: 2];
        end
    end

    // Next state, next counter and the next value of every registered output.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_score_nxt     = rsp_score;
        w_timeout_nxt   = rsp_timeout;
        w_req_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_v1_nxt        = 1'b0;
        w_v2_nxt        = 1'b0;
        w_color_nxt     = 3'd0;
        w_pos_nxt       = 6'd0;
        w_stripe_nxt    = 1'b0;
        w_action_nxt    = 2'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (r_cnt == C_LOAD_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state_nxt = ST_ACT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_ACT: begin
                if (r_cnt == C_ACT_LAST) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // A response in the last allowed cycle wins over the timeout.
                if (cc_out_valid) begin
                    w_state_nxt   = ST_RESP;
                    w_cnt_nxt     = '0;
                    w_score_nxt   = cc_out_score;
                    w_timeout_nxt = 1'b0;
                end else if (w_wait_inc == C_TIMEOUT) begin
                    w_state_nxt   = ST_RESP;
                    w_cnt_nxt     = '0;
                    w_score_nxt   = 7'd0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_wait_inc;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt   = ST_IDLE;
                    w_score_nxt   = 7'd0;
                    w_timeout_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            ST_IDLE: w_req_ready_nxt = 1'b1;
            ST_LOAD: begin
                w_v1_nxt    = 1'b1;
                w_color_nxt = w_cell[w_cnt_nxt[5:0]];
                if (w_cnt_nxt[CNT_W-1:2] == '0) begin
                    w_pos_nxt    = w_spos[w_cnt_nxt[1:0]];
                    w_stripe_nxt = w_stripe_type_src[w_cnt_nxt[1:0]];
                end
            end
            ST_ACT: begin
                w_v2_nxt     = 1'b1;
                w_pos_nxt    = w_apos[w_cnt_nxt[3:0]];
                w_action_nxt = w_adir[w_cnt_nxt[3:0]];
            end
            ST_RESP: w_rsp_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, counter, registered outputs and the sticky protocol monitor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            req_ready          <= 1'b1;
            rsp_valid          <= 1'b0;
            rsp_score          <= 7'd0;
            rsp_timeout        <= 1'b0;
            cc_in_valid_1      <= 1'b0;
            cc_in_valid_2      <= 1'b0;
            cc_in_color        <= 3'd0;
            cc_in_starting_pos <= 6'd0;
            cc_in_stripe       <= 1'b0;
            cc_in_action       <= 2'd0;
            r_prev_out_valid   <= 1'b0;
            proto_err          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            r_state            <= w_state_nxt;
            r_cnt              <= w_cnt_nxt;
            req_ready          <= w_req_ready_nxt;
            rsp_valid          <= w_rsp_valid_nxt;
            rsp_score          <= w_score_nxt;
            rsp_timeout        <= w_timeout_nxt;
            cc_in_valid_1      <= w_v1_nxt;
            cc_in_valid_2      <= w_v2_nxt;
            cc_in_color        <= w_color_nxt;
            cc_in_starting_pos <= w_pos_nxt;
            cc_in_stripe       <= w_stripe_nxt;
            cc_in_action       <= w_action_nxt;
            r_prev_out_valid   <= cc_out_valid;
            proto_err          <= proto_err | w_proto_viol;
        end
    end

    // Capture the whole record on acceptance; held untouched while busy.
    always_ff @(posedge clk) begin
        // NOTE: record storage has no reset; it is only read after an accept
        // has written it, so its power-up contents never reach an output.
        if (w_accept) begin
            r_color       <= req_color;
            r_stripe_pos  <= req_stripe_pos;
            r_stripe_type <= req_stripe_type;
            r_act_pos     <= req_act_pos;
            r_act_dir     <= req_act_dir;
        end
    end

endmodule

// File: doc/cc_game_sequencer.md
Name: cc_game_sequencer

Overview:
- Upstream driver for the CC candy-crush scoring core.
- Accepts one complete game record (6x6 board, 4 stripe candies, 10 swap actions) on a parallel valid/ready interface.
- Serializes the record into CC's in_valid_1 / in_valid_2 input protocol, waits for CC's single-cycle out_valid, and returns the score (or a timeout) on a response handshake.
- Also monitors CC output-protocol violations.

Parameters:
- GAP, 2: idle cycles between in_valid_1 falling and in_valid_2 rising (minimum 1).
- TIMEOUT, 500: cycles allowed in WAIT before timeout is declared.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  game record valid.
- req_ready  out  1  sequencer can accept a record.
- req_color  in  108  cell k (k=0..35, row-major, row=k/6, col=k%6) at [3k+2:3k].
- req_stripe_pos  in  24  stripe j (0..3) at [6j+5:6j], {row[2:0],col[2:0]}.
- req_stripe_type  in  4  stripe j type at bit j.
- req_act_pos  in  60  action m (0..9) at [6m+5:6m], {row,col}.
- req_act_dir  in  20  action m direction at [2m+1:2m].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_score  out  7  captured CC score.
- rsp_timeout  out  1  CC did not respond within TIMEOUT.
- cc_in_valid_1  out  1  to CC.
- cc_in_valid_2  out  1  to CC.
- cc_in_color  out  3  to CC.
- cc_in_starting_pos  out  6  to CC.
- cc_in_stripe  out  1  to CC.
- cc_in_action  out  2  to CC.
- cc_out_valid  in  1  from CC.
- cc_out_score  in  7  from CC.
- proto_err  out  1  sticky CC protocol violation flag.

Behaviour:
- Reset values:
  - All outputs registered and 0 at reset, except req_ready=1.
  - State=IDLE, counters 0, proto_err=0.
- States: IDLE, LOAD, GAP, ACT, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid&&req_ready latches the whole record into internal storage; next state LOAD, cycle index i=0.
  - req_ready is 0 in every other state.
- LOAD, 36 cycles:
  - cc_in_valid_1=1 starting the cycle after acceptance.
  - cc_in_color = cell i.
  - For i<4: cc_in_starting_pos = stripe i and cc_in_stripe = type i; for i>=4 both are driven 0.
  - cc_in_action=0.
  - After i=35, go to GAP.
- GAP: all cc_* inputs 0 for exactly GAP cycles, then ACT.
- ACT, 10 cycles:
  - cc_in_valid_2=1.
  - cc_in_starting_pos = action m, cc_in_action = dir m.
  - cc_in_color and cc_in_stripe are 0.
  - After m=9, go to WAIT with the wait counter at 0.
- WAIT:
  - Counter increments each cycle.
  - If cc_out_valid is seen: capture cc_out_score into rsp_score, rsp_timeout=0, go to RESP.
  - Else, when the counter reaches TIMEOUT: rsp_score=0, rsp_timeout=1, go to RESP.
  - out_valid on the same cycle the counter hits TIMEOUT counts as a valid response (no timeout).
- RESP:
  - rsp_valid=1 and held, with rsp_score and rsp_timeout stable, until rsp_ready.
  - The cycle after the handshake: rsp_valid=0, state IDLE, req_ready=1.
  - No request accepted in the handshake cycle itself.
- Total latency:
  - in_valid_1 rises 1 cycle after accept.
  - in_valid_2 rises 36+GAP cycles after that.
  - rsp_valid rises 1 cycle after cc_out_valid is sampled.
- proto_err is sticky until reset. It sets on any of:
  - cc_out_valid=1 outside WAIT;
  - cc_out_valid=1 on two consecutive cycles;
  - cc_out_score!=0 while cc_out_valid=0.
- proto_err does not alter sequencing.
- Reset asserted mid-operation (any state):
  - Immediate return to IDLE, all cc_* driven 0, pending result discarded, proto_err cleared.
- Record storage is not modified after acceptance; input changes while busy are ignored.

Test Plan:
- Single game: record with all cells color 1, stripes at {0,0},{1,1},{2,2},{3,3}, types 1010, actions at {5,5} dir 2; CC model returns 42.
  - Expect in_valid_1 high 36 cycles with colors in row-major order and stripe data only in the first 4 cycles.
  - Expect 2 idle cycles, then in_valid_2 high 10 cycles.
  - Expect rsp_valid with rsp_score=42, rsp_timeout=0.
- Back-to-back: two records with req_valid held and rsp_ready tied 1.
  - Expect second record accepted exactly 1 cycle after the first response handshake.
  - Expect scores 17 then 99 in order.
- Timeout: CC model never asserts out_valid.
  - Expect rsp_valid exactly TIMEOUT (500) cycles after in_valid_2 falls, with rsp_score=0 and rsp_timeout=1.
- Backpressure: rsp_ready held 0 for 20 cycles after a result of 63.
  - Expect rsp_valid and rsp_score=63 stable throughout; req_ready stays 0.
- Reset mid-LOAD: assert rst_n=0 at cell 20.
  - Expect all cc_* at 0 immediately, req_ready=1 after release.
  - A new record completes normally.
- Protocol errors: CC model holds out_valid 2 cycles, and separately drives out_score=5 with out_valid=0.
  - Expect proto_err=1 and remaining sticky in both cases.
  - Expect first-cycle score still returned.
